sprite_compositor: RTL and testbench

Parametrised N-sprite pixel compositor that replaces the fixed three-sprite display stage. It sits between the VGA timing generator and the VGA pins. It takes the raster position plus per-sprite rectangles from game logic and commits them atomically at each frame boundary through a valid/ready handshake. It emits pipelined, sync-aligned RGB with index-priority overlap resolution.

---
 rtl/sprite_compositor_if.sv | 27 ++
 rtl/sprite_compositor.sv | 189 ++++++++++++++++++
 tb/tb_sprite_compositor.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_compositor_if.sv
// Sprite-set update bus between game logic (master) and the compositor (slave).
// A whole rectangle set is offered with pos_valid and taken on pos_ready.
interface sprite_compositor_if #(
    parameter int NUM_SPRITES = 3,
    parameter int X_POS_W     = 10,
    parameter int Y_POS_W     = 10,
    parameter int RGB_W       = 12
);
    logic                           pos_valid;
    logic                           pos_ready;
    logic [NUM_SPRITES*X_POS_W-1:0] sprite_x;
    logic [NUM_SPRITES*Y_POS_W-1:0] sprite_y;
    logic [NUM_SPRITES*X_POS_W-1:0] sprite_w;
    logic [NUM_SPRITES*Y_POS_W-1:0] sprite_h;
    logic [NUM_SPRITES*RGB_W-1:0]   sprite_rgb;
    logic [NUM_SPRITES-1:0]         sprite_en;

    modport master (
        output pos_valid, sprite_x, sprite_y, sprite_w, sprite_h, sprite_rgb, sprite_en,
        input  pos_ready
    );

    modport slave (
        input  pos_valid, sprite_x, sprite_y, sprite_w, sprite_h, sprite_rgb, sprite_en,
        output pos_ready
    );
endinterface

// File: rtl/sprite_compositor.sv
// N-sprite rectangle compositor: frame-atomic shadow update, 2-stage hit/priority pipeline.
// Optional dashed centre separator enabled by defining SPRITE_COMPOSITOR_SEPARATOR_EN.
module sprite_compositor #(
    parameter int NUM_SPRITES = 3,
    parameter int X_POS_W     = 10,
    parameter int Y_POS_W     = 10,
    parameter int RGB_W       = 12,
    parameter int H_RES       = 640,
    parameter int SEP_W       = 4,
    parameter int SEP_PERIOD  = 32,
    parameter int SEP_DOT_H   = 16,
    parameter int SEP_PHASE   = 9
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [X_POS_W-1:0] pixel_x_i,
    input  logic [Y_POS_W-1:0] pixel_y_i,
    input  logic               visible_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    sprite_compositor_if.slave pos,
    output logic               vga_hs_o,
    output logic               vga_vs_o,
    output logic [RGB_W-1:0]   vga_rgb_o,
    output logic               new_frame_o,
    output logic [7:0]         stale_frames_o
);

    generate
        if ((SEP_W % 2) != 0 || SEP_PERIOD <= 0 || (SEP_PERIOD & (SEP_PERIOD - 1)) != 0 ||
            SEP_DOT_H > SEP_PERIOD || SEP_PHASE < 0 || H_RES < SEP_W) begin : g_bad_cfg
            $error("sprite_compositor: inconsistent separator parameters");
        end
    endgenerate

    // Frame start detection and the update handshake
    logic       vs_prev_reg;
    logic       new_frame_reg;
    logic [7:0] stale_reg;
    logic       accept;

    assign accept        = pos.pos_valid & new_frame_reg;
    assign pos.pos_ready = new_frame_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_prev_reg   <= 1'b0;
            new_frame_reg <= 1'b0;
            stale_reg     <= 8'd0;
        end else begin
            vs_prev_reg   <= vsync_i;
            new_frame_reg <= vs_prev_reg & ~vsync_i;
            if (new_frame_reg && !pos.pos_valid && stale_reg != 8'hFF)
                stale_reg <= stale_reg + 8'd1;
        end
    end

    assign new_frame_o    = new_frame_reg;
    assign stale_frames_o = stale_reg;

    // Per-sprite shadow registers and stage-1 hit test
    logic [NUM_SPRITES-1:0] hit_vec;
    logic [RGB_W-1:0]       rgb_arr [NUM_SPRITES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
            logic [X_POS_W-1:0] x_reg, w_reg;
            logic [Y_POS_W-1:0] y_reg, h_reg;
            logic [RGB_W-1:0]   rgb_reg;
            logic               en_reg;
            logic [X_POS_W:0]   x_end;
            logic [Y_POS_W:0]   y_end;
            logic               hit;
            logic               hit1_reg;
            logic [RGB_W-1:0]   rgb1_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    x_reg   <= '0;
                    y_reg   <= '0;
                    w_reg   <= '0;
                    h_reg   <= '0;
                    rgb_reg <= '0;
                    en_reg  <= 1'b0;
                end else if (accept) begin
                    x_reg   <= pos.sprite_x[gi*X_POS_W +: X_POS_W];
                    y_reg   <= pos.sprite_y[gi*Y_POS_W +: Y_POS_W];
                    w_reg   <= pos.sprite_w[gi*X_POS_W +: X_POS_W];
                    h_reg   <= pos.sprite_h[gi*Y_POS_W +: Y_POS_W];
                    rgb_reg <= pos.sprite_rgb[gi*RGB_W +: RGB_W];
                    en_reg  <= pos.sprite_en[gi];
                end
            end

            // One extra bit keeps a rectangle hanging off the edge from wrapping to 0
            assign x_end = {1'b0, x_reg} + {1'b0, w_reg};
            assign y_end = {1'b0, y_reg} + {1'b0, h_reg};
            assign hit   = en_reg & visible_i &
                           (pixel_x_i >= x_reg) & ({1'b0, pixel_x_i} < x_end) &
                           (pixel_y_i >= y_reg) & ({1'b0, pixel_y_i} < y_end);

            // Colour travels with the hit so in-flight pixels keep the old set
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    hit1_reg <= 1'b0;
                    rgb1_reg <= '0;
                end else begin
                    hit1_reg <= hit;
                    rgb1_reg <= rgb_reg;
                end
            end

            assign hit_vec[gi] = hit1_reg;
            assign rgb_arr[gi] = rgb1_reg;
        end
    endgenerate

    // Stage-1 raster side band
    logic vis1_reg, hs1_reg, vs1_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vis1_reg <= 1'b0;
            hs1_reg  <= 1'b1;
            vs1_reg  <= 1'b1;
        end else begin
            vis1_reg <= visible_i;
            hs1_reg  <= hsync_i;
            vs1_reg  <= vsync_i;
        end
    end

`ifdef SPRITE_COMPOSITOR_SEPARATOR_EN
    localparam int SEP_LO = H_RES / 2 - SEP_W / 2;
    localparam int SEP_HI = H_RES / 2 + SEP_W / 2;

    logic [X_POS_W-1:0] px1_reg;
    logic [Y_POS_W-1:0] py1_reg;
    logic [Y_POS_W:0]   sep_row;
    logic               sep_on;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            px1_reg <= '0;
            py1_reg <= '0;
        end else begin
            px1_reg <= pixel_x_i;
            py1_reg <= pixel_y_i;
        end
    end

    assign sep_row = ({1'b0, py1_reg} + (Y_POS_W + 1)'(SEP_PHASE)) & (Y_POS_W + 1)'(SEP_PERIOD - 1);
    assign sep_on  = vis1_reg &
                     ({1'b0, px1_reg} > (X_POS_W + 1)'(SEP_LO)) &
                     ({1'b0, px1_reg} < (X_POS_W + 1)'(SEP_HI)) &
                     (sep_row < (Y_POS_W + 1)'(SEP_DOT_H));
`endif

    // Stage 2: lowest index wins, so scan from the top down
    logic [RGB_W-1:0] rgb_next;

    always_comb begin
        rgb_next = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (hit_vec[k])
                rgb_next = rgb_arr[k];
        end
        if (!vis1_reg)
            rgb_next = '0;
`ifdef SPRITE_COMPOSITOR_SEPARATOR_EN
        if (sep_on)
            rgb_next = '1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vga_rgb_o <= '0;
            vga_hs_o  <= 1'b1;
            vga_vs_o  <= 1'b1;
        end else begin
            vga_rgb_o <= rgb_next;
            vga_hs_o  <= hs1_reg;
            vga_vs_o  <= vs1_reg;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: vector table for pixel hits plus
// hand-written sequences for frame handshake, sync delay, saturation and reset.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        visible = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        vga_hs, vga_vs, new_frame;
    logic [11:0] vga_rgb;
    logic [7:0]  stale;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sprite_compositor_if #(.NUM_SPRITES(3), .X_POS_W(10), .Y_POS_W(10), .RGB_W(12)) pif ();

    sprite_compositor dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pixel_x_i      (pixel_x),
        .pixel_y_i      (pixel_y),
        .visible_i      (visible),
        .hsync_i        (hsync),
        .vsync_i        (vsync),
        .pos            (pif),
        .vga_hs_o       (vga_hs),
        .vga_vs_o       (vga_vs),
        .vga_rgb_o      (vga_rgb),
        .new_frame_o    (new_frame),
        .stale_frames_o (stale)
    );

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        vis;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t va [13];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h required %0h", nm, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", nm, got);
        end
    endtask

    task automatic set_sprite(input int k, input logic [9:0] x, input logic [9:0] y,
                              input logic [9:0] w, input logic [9:0] h,
                              input logic [11:0] rgb, input logic en);
        pif.sprite_x[k*10 +: 10]   = x;
        pif.sprite_y[k*10 +: 10]   = y;
        pif.sprite_w[k*10 +: 10]   = w;
        pif.sprite_h[k*10 +: 10]   = h;
        pif.sprite_rgb[k*12 +: 12] = rgb;
        pif.sprite_en[k]           = en;
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic vis,
                       input logic [11:0] exp, input string nm);
        @(negedge clk);
        pixel_x = px;
        pixel_y = py;
        visible = vis;
        @(posedge clk);
        @(posedge clk);
        #1 check(nm, {20'd0, vga_rgb}, {20'd0, exp});
    endtask

    // vsync high for one cycle then low; acceptance happens on the edge after the pulse
    task automatic frame_start(input bit chk);
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        if (chk) check("nf_before_edge", {31'd0, new_frame}, 32'd0);
        @(posedge clk);
        #1;
        if (chk) begin
            check("nf_pulse", {31'd0, new_frame}, 32'd1);
            check("ready_pulse", {31'd0, pif.pos_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        if (chk) begin
            check("nf_width", {31'd0, new_frame}, 32'd0);
            check("ready_drop", {31'd0, pif.pos_ready}, 32'd0);
        end
    endtask

    initial begin
        pif.pos_valid  = 1'b0;
        pif.sprite_x   = '0;
        pif.sprite_y   = '0;
        pif.sprite_w   = '0;
        pif.sprite_h   = '0;
        pif.sprite_rgb = '0;
        pif.sprite_en  = '0;

        // Set A vectors
        va[0]  = '{10'd100, 10'd50,  1'b1, 12'hF00, "s0_topleft"};
        va[1]  = '{10'd107, 10'd57,  1'b1, 12'hF00, "s0_botright"};
        va[2]  = '{10'd108, 10'd50,  1'b1, 12'h000, "s0_right_edge"};
        va[3]  = '{10'd99,  10'd50,  1'b1, 12'h000, "s0_left_edge"};
        va[4]  = '{10'd100, 10'd58,  1'b1, 12'h000, "s0_bottom_edge"};
        va[5]  = '{10'd100, 10'd50,  1'b0, 12'h000, "s0_invisible"};
        va[6]  = '{10'd400, 10'd300, 1'b1, 12'h0F0, "s1_topleft"};
        va[7]  = '{10'd415, 10'd315, 1'b1, 12'h0F0, "s1_botright"};
        va[8]  = '{10'd416, 10'd300, 1'b1, 12'h000, "s1_right_edge"};
        va[9]  = '{10'd636, 10'd60,  1'b1, 12'h00F, "s2_x636"};
        va[10] = '{10'd639, 10'd63,  1'b1, 12'h00F, "s2_x639"};
        va[11] = '{10'd0,   10'd60,  1'b1, 12'h000, "s2_no_wrap_x0"};
        va[12] = '{10'd635, 10'd60,  1'b1, 12'h000, "s2_left_edge"};

        // Reset state, syncs held low at the input to show output syncs reset high
        hsync = 1'b0;
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", {20'd0, vga_rgb}, 32'd0);
        check("rst_hs", {31'd0, vga_hs}, 32'd1);
        check("rst_vs", {31'd0, vga_vs}, 32'd1);
        check("rst_nf", {31'd0, new_frame}, 32'd0);
        check("rst_ready", {31'd0, pif.pos_ready}, 32'd0);
        check("rst_stale", {24'd0, stale}, 32'd0);
        @(negedge clk);
        hsync = 1'b1;
        rst   = 1'b0;

        // Frame without update: black and stale=1
        frame_start(1'b1);
        check("stale_first", {24'd0, stale}, 32'd1);
        pix(10'd100, 10'd50, 1'b1, 12'h000, "black_no_update");
        pix(10'd0, 10'd0, 1'b1, 12'h000, "black_origin");

        // Sync delay of exactly two cycles
        @(negedge clk) hsync = 1'b0;
        @(posedge clk) #1 check("hs_d1", {31'd0, vga_hs}, 32'd1);
        @(negedge clk) hsync = 1'b1;
        @(posedge clk) #1 check("hs_d2", {31'd0, vga_hs}, 32'd0);
        @(posedge clk) #1 check("hs_d3", {31'd0, vga_hs}, 32'd1);

        // Set A
        set_sprite(0, 10'd100, 10'd50,  10'd8,  10'd8,  12'hF00, 1'b1);
        set_sprite(1, 10'd400, 10'd300, 10'd16, 10'd16, 12'h0F0, 1'b1);
        set_sprite(2, 10'd636, 10'd60,  10'd8,  10'd4,  12'h00F, 1'b1);
        pif.pos_valid = 1'b1;
        frame_start(1'b0);
        @(negedge clk) pif.pos_valid = 1'b0;
        check("stale_after_accept", {24'd0, stale}, 32'd1);
        for (int i = 0; i < 13; i++)
            pix(va[i].px, va[i].py, va[i].vis, va[i].exp, va[i].name);

        // Set B offered mid-frame while ready is low: ignored
        set_sprite(0, 10'd190, 10'd190, 10'd20, 10'd20, 12'hF00, 1'b1);
        set_sprite(1, 10'd196, 10'd196, 10'd10, 10'd10, 12'h0F0, 1'b1);
        set_sprite(2, 10'd300, 10'd300, 10'd0,  10'd5,  12'h00F, 1'b1);
        @(negedge clk) pif.pos_valid = 1'b1;
        @(negedge clk) pif.pos_valid = 1'b0;
        pix(10'd100, 10'd50, 1'b1, 12'hF00, "midframe_ignored");
        pix(10'd200, 10'd200, 1'b1, 12'h000, "midframe_no_new");

        // Set B accepted at frame start
        pif.pos_valid = 1'b1;
        frame_start(1'b0);
        @(negedge clk) pif.pos_valid = 1'b0;
        pix(10'd200, 10'd200, 1'b1, 12'hF00, "overlap_low_index");
        pix(10'd192, 10'd192, 1'b1, 12'hF00, "s0_only");
        pix(10'd300, 10'd300, 1'b1, 12'h000, "w0_never_hits");
        pix(10'd100, 10'd50, 1'b1, 12'h000, "old_set_gone");

        // Set C (sprite0 disabled) held valid: visible only after the next frame start
        set_sprite(0, 10'd190, 10'd190, 10'd20, 10'd20, 12'hF00, 1'b0);
        pif.pos_valid = 1'b1;
        pix(10'd200, 10'd200, 1'b1, 12'hF00, "held_before_frame");
        frame_start(1'b0);
        pix(10'd200, 10'd200, 1'b1, 12'h0F0, "s0_disabled");
        pix(10'd192, 10'd192, 1'b1, 12'h000, "s0_disabled_only");

        // Still valid across the next frame: accepted again
        set_sprite(1, 10'd196, 10'd196, 10'd10, 10'd10, 12'h0FF, 1'b1);
        frame_start(1'b0);
        @(negedge clk) pif.pos_valid = 1'b0;
        pix(10'd200, 10'd200, 1'b1, 12'h0FF, "held_valid_reaccept");
        check("stale_held_valid", {24'd0, stale}, 32'd1);

        // Sprite under the centre separator
        set_sprite(0, 10'd316, 10'd0, 10'd8, 10'd40, 12'hABC, 1'b1);
        set_sprite(1, 10'd0, 10'd0, 10'd0, 10'd0, 12'h000, 1'b0);
        set_sprite(2, 10'd0, 10'd0, 10'd0, 10'd0, 12'h000, 1'b0);
        pif.pos_valid = 1'b1;
        frame_start(1'b0);
        @(negedge clk) pif.pos_valid = 1'b0;
`ifdef SPRITE_COMPOSITOR_SEPARATOR_EN
        pix(10'd320, 10'd23, 1'b1, 12'hFFF, "sep_lit_320");
        pix(10'd321, 10'd23, 1'b1, 12'hFFF, "sep_lit_321");
`else
        pix(10'd320, 10'd23, 1'b1, 12'hABC, "nosep_320");
        pix(10'd321, 10'd23, 1'b1, 12'hABC, "nosep_321");
`endif
        pix(10'd320, 10'd7,  1'b1, 12'hABC, "sep_dark_row");
        pix(10'd318, 10'd23, 1'b1, 12'hABC, "sep_left_out");
        pix(10'd322, 10'd23, 1'b1, 12'hABC, "sep_right_out");

        // Stale counter saturation
        repeat (253) frame_start(1'b0);
        check("stale_254", {24'd0, stale}, 32'd254);
        frame_start(1'b0);
        check("stale_255", {24'd0, stale}, 32'd255);
        repeat (3) frame_start(1'b0);
        check("stale_saturated", {24'd0, stale}, 32'd255);

        // Reset mid-frame with a sprite on screen
        @(negedge clk);
        pixel_x = 10'd318;
        pixel_y = 10'd10;
        visible = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_rgb", {20'd0, vga_rgb}, 32'd0);
        check("midrst_stale", {24'd0, stale}, 32'd0);
        @(negedge clk) rst = 1'b0;
        pix(10'd318, 10'd10, 1'b1, 12'h000, "post_rst_black");
        frame_start(1'b0);
        check("post_rst_stale", {24'd0, stale}, 32'd1);
        pix(10'd318, 10'd10, 1'b1, 12'h000, "post_rst_still_black");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
